hazard_fwd_ctrl: RTL
====================

// Module: hazard_fwd_ctrl
// PURPOSE
//  Decode-side hazard/forwarding controller feeding the register bank's operand muxes.
//  Tracks destination registers of in-flight instructions (OP, EX, DM, WB) and registers mux_sel_A/B and imm_sel.
//  Stalls decode one cycle on load-use hazards and drives RW_dm/dm_we for the DM-stage register write.
// PARAMETERS
//  RA_W      5   register address width (32-entry bank)
//  STAT_W    16  width of stall counter (FWD_STATS_EN only)
// PORTS
//  clk         in   1      clock, rising edge
//  rst         in   1      asynchronous, active-high reset
//  id_valid    in   1      decode-stage instruction present
//  id_RA       in   RA_W   source A register
//  id_RB       in   RA_W   source B register
//  id_RW       in   RA_W   destination register
//  id_we       in   1      instruction writes id_RW
//  id_is_load  in   1      instruction is a load (result in ans_dm, not ans_ex)
//  id_use_imm  in   1      B operand is immediate
//  flush       in   1      kill decode and OP-stage instructions (branch taken)
//  mux_sel_A   out  2      00 reg, 01 ans_ex, 10 ans_dm, 11 ans_wb (registered)
//  mux_sel_B   out  2      same encoding for B (registered)
//  imm_sel     out  1      registered id_use_imm of instruction entering OP
//  stall       out  1      combinational: hold fetch/decode this cycle
//  RW_dm       out  RA_W   destination of DM-stage instruction
//  dm_we       out  1      DM-stage instruction valid and writes
//  stall_cnt   out  STAT_W stalls inserted since reset (FWD_STATS_EN only)
// BEHAVIOUR
//  - Slots OP,EX,DM,WB each hold {v, we, ld, rw}. Effective writer = v & we.
//  - stall = id_valid & OP.v & OP.we & OP.ld & (id_RA==OP.rw | (~id_use_imm & id_RB==OP.rw)).
//  - Each posedge: WB<=DM, DM<=EX, EX<=OP. OP<=decode fields with v=id_valid & ~stall & ~flush;
//    on stall OP gets a bubble (v=0); decode inputs held externally.
//  - Selection for instruction entering OP (computed from id_RA/id_RB vs slots before shift):
//    match OP -> 01 (becomes EX), else match EX -> 10 (becomes DM), else match DM -> 11, else 00.
//    Nearest (youngest) writer wins. Only effective writers match. R0 forwarded like any register.
//  - Load in OP never selects 01: by stall it reaches DM first, then matches EX -> 10.
//  - On stall or bubble, mux_sel_A/B<=00 and imm_sel<=0.
//  - flush: OP.v<=0 and decode killed same edge; EX/DM/WB continue; flush overrides stall.
//  - RW_dm = DM.rw; dm_we = DM.v & DM.we. RW_dm held at last value when DM is a bubble.
//  - Reset (async, any time): all slot v/we/ld and rw cleared to 0; mux_sel_A/B=00, imm_sel=0,
//    RW_dm=0, dm_we=0, stall=0 (no valid slots), stall_cnt=0. Mid-stream reset drops all in-flight state.
// CONFIGURATION
//  FWD_STATS_EN defined: stall_cnt increments on each cycle stall=1 & ~flush, saturates at all-ones.
//  Undefined: stall_cnt port absent, no counter logic.
// STRUCTURE
//  Package hazard_pkg: SEL_REG/SEL_EX/SEL_DM/SEL_WB 2-bit constants, slot struct {v,we,ld,rw}.
//  Sub-module fwd_sel: combinational priority compare (one src vs OP/EX/DM) -> 2-bit sel;
//  instantiated twice (A, B).
// TESTING
//  1. ADD r3 then ADD r4,r3,r1 back-to-back -> second gets mux_sel_A=01, no stall.
//  2. r3 writers two and three ahead, consumer reads r3 -> sel 10 (youngest wins), not 11.
//  3. LD r5 then ADD r6,r5,r2 -> stall=1 one cycle, bubble in OP, then mux_sel_A=10.
//  4. LD r5 then ADDI r6,r2,#imm with id_RB=r5, id_use_imm=1 -> no stall, imm_sel=1.
//  5. flush while stall=1 -> OP bubble, no sel from killed instr; DM writer still gives dm_we=1.
//  6. rst pulse mid-stream (async, off-edge) -> outputs 0 immediately; FWD_STATS_EN: stall_cnt=0.

Source files
------------

// File: rtl/hazard_fwd_ctrl_pkg.sv
// hazard_pkg: shared constants and slot types for hazard_fwd_ctrl.
// Mux select codes name the stage whose result feeds the operand.
package hazard_pkg;

  localparam int RA_W   = 5;
  localparam int STAT_W = 16;

  localparam logic [1:0] SEL_REG = 2'b00;
  localparam logic [1:0] SEL_EX  = 2'b01;
  localparam logic [1:0] SEL_DM  = 2'b10;
  localparam logic [1:0] SEL_WB  = 2'b11;

  // OP slot: the load flag only matters while the load sits in OP
  typedef struct packed {
    logic            v;
    logic            we;
    logic            ld;
    logic [RA_W-1:0] rw;
  } slot_t;

  // EX/DM slots: past OP a load's result has a fixed forward path
  typedef struct packed {
    logic            v;
    logic            we;
    logic [RA_W-1:0] rw;
  } pipe_t;

  function automatic logic wr_hit(
    input logic            v,
    input logic            we,
    input logic [RA_W-1:0] rw,
    input logic [RA_W-1:0] src
  );
    return v & we & (rw == src);
  endfunction

endpackage

// File: rtl/hazard_fwd_ctrl_if.sv
// hazard_fwd_ctrl_if: decode fields in, operand selects out.
// stall_cnt exists only when FWD_STATS_EN is defined.
interface hazard_fwd_ctrl_if;
  import hazard_pkg::*;

  logic            id_valid;
  logic [RA_W-1:0] id_RA;
  logic [RA_W-1:0] id_RB;
  logic [RA_W-1:0] id_RW;
  logic            id_we;
  logic            id_is_load;
  logic            id_use_imm;
  logic            flush;
  logic [1:0]      mux_sel_A;
  logic [1:0]      mux_sel_B;
  logic            imm_sel;
  logic            stall;
  logic [RA_W-1:0] RW_dm;
  logic            dm_we;
`ifdef FWD_STATS_EN
  logic [STAT_W-1:0] stall_cnt;
`endif

  modport master (
    output id_valid, id_RA, id_RB, id_RW,
    output id_we, id_is_load, id_use_imm, flush,
    input  mux_sel_A, mux_sel_B, imm_sel,
    input  stall, RW_dm, dm_we
`ifdef FWD_STATS_EN
    , input stall_cnt
`endif
  );

  modport slave (
    input  id_valid, id_RA, id_RB, id_RW,
    input  id_we, id_is_load, id_use_imm, flush,
    output mux_sel_A, mux_sel_B, imm_sel,
    output stall, RW_dm, dm_we
`ifdef FWD_STATS_EN
    , output stall_cnt
`endif
  );

endinterface

// File: rtl/hazard_fwd_ctrl_fwd_sel.sv
// fwd_sel: youngest-writer priority compare of one source register.
// A load in OP is skipped; its data is not on ans_ex.
module fwd_sel
  import hazard_pkg::*;
(
  input  logic [RA_W-1:0] src,
  input  slot_t           op,
  input  pipe_t           ex,
  input  pipe_t           dm,
  output logic [1:0]      sel
);

  logic hit_op;
  logic hit_ex;
  logic hit_dm;

  assign hit_op = wr_hit(op.v, op.we, op.rw, src) & ~op.ld;
  assign hit_ex = wr_hit(ex.v, ex.we, ex.rw, src);
  assign hit_dm = wr_hit(dm.v, dm.we, dm.rw, src);

  // nearest writer wins; stages shift one step as the consumer enters OP
  always_comb begin
    sel = SEL_REG;
    priority case (1'b1)
      hit_op:  sel = SEL_EX;
      hit_ex:  sel = SEL_DM;
      hit_dm:  sel = SEL_WB;
      default: sel = SEL_REG;
    endcase
  end

endmodule

// File: rtl/hazard_fwd_ctrl.sv
// hazard_fwd_ctrl: load-use stall and operand forwarding selects.
// Build option FWD_STATS_EN adds a saturating stall counter.
module hazard_fwd_ctrl
  import hazard_pkg::*;
(
  input logic              clk,
  input logic              rst,
  hazard_fwd_ctrl_if.slave bus
);

  slot_t      op_q;
  pipe_t      ex_q;
  pipe_t      dm_q;
  logic       ld_op;
  logic       stall;
  logic       accept;
  logic [1:0] sel_a;
  logic [1:0] sel_b;

  assign ld_op = op_q.v & op_q.we & op_q.ld;

  assign stall = bus.id_valid & ld_op
               & ((bus.id_RA == op_q.rw)
               | (~bus.id_use_imm & (bus.id_RB == op_q.rw)));

  assign accept = bus.id_valid & ~stall & ~bus.flush;

  fwd_sel u_sel_a (
    .src (bus.id_RA),
    .op  (op_q),
    .ex  (ex_q),
    .dm  (dm_q),
    .sel (sel_a)
  );

  fwd_sel u_sel_b (
    .src (bus.id_RB),
    .op  (op_q),
    .ex  (ex_q),
    .dm  (dm_q),
    .sel (sel_b)
  );

  // advance slots; flush kills decode and the OP instruction
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      op_q <= '0;
      ex_q <= '0;
      dm_q <= '0;
    end else begin
      op_q.v  <= accept;
      op_q.we <= bus.id_we;
      op_q.ld <= bus.id_is_load;
      op_q.rw <= bus.id_RW;
      ex_q.v  <= op_q.v & ~bus.flush;
      ex_q.we <= op_q.we;
      ex_q.rw <= op_q.rw;
      dm_q.v  <= ex_q.v;
      dm_q.we <= ex_q.we;
      if (ex_q.v) dm_q.rw <= ex_q.rw;
    end
  end

  // register selects for the instruction entering OP
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      bus.mux_sel_A <= SEL_REG;
      bus.mux_sel_B <= SEL_REG;
      bus.imm_sel   <= 1'b0;
    end else if (accept) begin
      bus.mux_sel_A <= sel_a;
      bus.mux_sel_B <= sel_b;
      bus.imm_sel   <= bus.id_use_imm;
    end else begin
      bus.mux_sel_A <= SEL_REG;
      bus.mux_sel_B <= SEL_REG;
      bus.imm_sel   <= 1'b0;
    end
  end

  assign bus.stall = stall;
  assign bus.RW_dm = dm_q.rw;
  assign bus.dm_we = dm_q.v & dm_q.we;

`ifdef FWD_STATS_EN
  logic [STAT_W-1:0] cnt_q;

  // count inserted bubbles, saturating
  always_ff @(posedge clk or posedge rst) begin
    if (rst) cnt_q <= '0;
    else if (stall & ~bus.flush & ~&cnt_q)
      cnt_q <= cnt_q + 1'b1;
  end

  assign bus.stall_cnt = cnt_q;
`endif

endmodule
